// File: rtl/stress_pkg.sv
// Shared types and constants for the stress_sensor block: level encoding,
// default classification thresholds and the uio bit positions.
package stress_pkg;

    // Stress classification levels, ordered so that "up" is +1.
    typedef enum logic [1:0] {
        LVL_CALM     = 2'd0,
        LVL_MILD     = 2'd1,
        LVL_ELEVATED = 2'd2,
        LVL_HIGH     = 2'd3
    } level_e;

    // Default window depth and classification constants.
    localparam int DEF_AVG_LOG2  = 3;
    localparam int DEF_THR1      = 80;
    localparam int DEF_THR2      = 128;
    localparam int DEF_THR3      = 176;
    localparam int DEF_HYST      = 8;
    localparam int DEF_ALARM_CNT = 16;

    // Bit positions inside uio_in / uio_out.
    localparam int IDX_VALID  = 0;
    localparam int IDX_CLEAR  = 1;
    localparam int IDX_PEAK   = 2;
    localparam int IDX_AVALID = 4;
    localparam int IDX_LEVEL  = 5;
    localparam int IDX_ALARM  = 7;

endpackage

// File: rtl/stress_moving_avg.sv
// Sliding-window moving average over 2^AVG_LOG2 8-bit samples.
// The window is zero-prefilled, so the average ramps up while filling;
// o_avg_valid rises once the window has seen a full set of samples.
module stress_moving_avg #(
    parameter int AVG_LOG2 = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_accept,
    input  logic [7:0] i_sample,
    output logic [7:0] o_avg,
    output logic       o_avg_valid
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 8 + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_MAX = (AVG_LOG2 + 1)'(N);

    logic [7:0]        r_win [N];
    logic [SW-1:0]     r_sum;
    logic [7:0]        r_avg;
    logic [AVG_LOG2:0] r_fill;
    logic              r_avg_valid;
    logic [SW-1:0]     w_sum_next;

    // The sum always contains the oldest sample, so the subtraction never wraps.
    assign w_sum_next = r_sum + SW'(i_sample) - SW'(r_win[N-1]);

    // Window shift, running sum, registered average and fill tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                r_win[i] <= 8'd0;
            end
            r_sum       <= '0;
            r_avg       <= 8'd0;
            r_fill      <= '0;
            r_avg_valid <= 1'b0;
        end else if (i_accept) begin
            r_win[0] <= i_sample;
            for (int i = 1; i < N; i++) begin
                r_win[i] <= r_win[i-1];
            end
            r_sum <= w_sum_next;
            r_avg <= w_sum_next[SW-1:AVG_LOG2];
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + 1'b1;
            end
            if (r_fill == FILL_MAX - 1'b1) begin
                r_avg_valid <= 1'b1;
            end
        end
    end

    assign o_avg       = r_avg;
    assign o_avg_valid = r_avg_valid;

endmodule

// File: rtl/stress_sensor.sv
// Stress indicator: moving average of physiological samples classified into
// four levels with hysteresis, plus a sticky alarm after sustained level 3.
// Optional peak-hold display is enabled by defining STRESS_PEAK_HOLD_EN.
//
// Sample interface: uio_in[0] is a level-sensitive valid strobe with no
// backpressure; every clock with ena=1 and the strobe high accepts ui_in.
module stress_sensor
    import stress_pkg::*;
#(
    parameter int AVG_LOG2  = DEF_AVG_LOG2,
    parameter int THR1      = DEF_THR1,
    parameter int THR2      = DEF_THR2,
    parameter int THR3      = DEF_THR3,
    parameter int HYST      = DEF_HYST,
    parameter int ALARM_CNT = DEF_ALARM_CNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = $clog2(ALARM_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(ALARM_CNT);
    localparam logic [8:0] L_UP1 = 9'(THR1);
    localparam logic [8:0] L_UP2 = 9'(THR2);
    localparam logic [8:0] L_UP3 = 9'(THR3);
    localparam logic [8:0] L_DN1 = 9'(THR1 - HYST);
    localparam logic [8:0] L_DN2 = 9'(THR2 - HYST);
    localparam logic [8:0] L_DN3 = 9'(THR3 - HYST);

    logic          w_accept;
    logic          w_clear;
    logic [7:0]    w_avg;
    logic [8:0]    w_avg9;
    logic          w_avg_valid;
    level_e        r_level;
    level_e        w_level_next;
    logic [CW-1:0] r_alarm_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_alarm;
    logic          w_alarm_next;
    logic          w_unused;

    assign w_accept = ena & uio_in[IDX_VALID];
    assign w_clear  = uio_in[IDX_CLEAR];
    assign w_avg9   = {1'b0, w_avg};

    stress_moving_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_accept    (w_accept),
        .i_sample    (ui_in),
        .o_avg       (w_avg),
        .o_avg_valid (w_avg_valid)
    );

    // Level next-state: at most one step per clock, hysteresis on the way down.
    always_comb begin
        w_level_next = r_level;
        unique case (r_level)
            LVL_CALM: begin
                if (w_avg9 >= L_UP1) w_level_next = LVL_MILD;
            end
            LVL_MILD: begin
                if (w_avg9 >= L_UP2)     w_level_next = LVL_ELEVATED;
                else if (w_avg9 < L_DN1) w_level_next = LVL_CALM;
            end
            LVL_ELEVATED: begin
                if (w_avg9 >= L_UP3)     w_level_next = LVL_HIGH;
                else if (w_avg9 < L_DN2) w_level_next = LVL_MILD;
            end
            LVL_HIGH: begin
                if (w_avg9 < L_DN3) w_level_next = LVL_ELEVATED;
            end
        endcase
    end

    // Alarm counter and sticky alarm; clear wins over a simultaneous set.
    always_comb begin
        w_cnt_next = r_alarm_cnt;
        if (w_clear) begin
            w_cnt_next = '0;
        end else if (w_accept) begin
            if (r_level == LVL_HIGH) begin
                if (r_alarm_cnt != CNT_MAX) w_cnt_next = r_alarm_cnt + 1'b1;
            end else begin
                w_cnt_next = '0;
            end
        end
        w_alarm_next = w_clear ? 1'b0 : (r_alarm | (w_cnt_next == CNT_MAX));
    end

    // Level, alarm counter and alarm state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level     <= LVL_CALM;
            r_alarm_cnt <= '0;
            r_alarm     <= 1'b0;
        end else begin
            r_level     <= w_level_next;
            r_alarm_cnt <= w_cnt_next;
            r_alarm     <= w_alarm_next;
        end
    end

`ifdef STRESS_PEAK_HOLD_EN
    logic [7:0] r_peak;

    // Peak of the average, tracked every clock and cleared with the alarm.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_peak <= 8'd0;
        end else if (w_avg > r_peak) begin
            r_peak <= w_avg;
        end
    end

    assign uo_out   = uio_in[IDX_PEAK] ? r_peak : w_avg;
    assign w_unused = &{1'b0, uio_in[7:3]};
`else
    assign uo_out   = w_avg;
    assign w_unused = &{1'b0, uio_in[7:2]};
`endif

    assign uio_out = {r_alarm, r_level, w_avg_valid, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_stress_sensor.sv
// Self-checking bench for stress_sensor: table-driven fill/climb vectors,
// hand-written alarm, gating and hysteresis sequences, then random traffic
// checked against a behavioural model through an expected-value queue.
module tb_stress_sensor;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

`ifdef STRESS_PEAK_HOLD_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  stress_sensor dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  // behavioural model state
  int m_win[8];
  int m_fill, m_avg, m_level, m_cnt, m_peak;
  bit m_avalid, m_alarm;
  int thr[4] = '{0, 80, 128, 176};

  typedef struct {
    logic [7:0] sample;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;
  vec_t tbl[16];

  task automatic check_val(string name, int got, int exp_v);
    n_tests++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_win[i] = 0;
    m_fill = 0; m_avg = 0; m_level = 0; m_cnt = 0; m_peak = 0;
    m_avalid = 0; m_alarm = 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(bit e, bit v, bit c, logic [7:0] s);
    int lvl_n, cnt_n, sum;
    lvl_n = m_level;
    if (m_level < 3 && m_avg >= thr[m_level + 1]) lvl_n = m_level + 1;
    else if (m_level > 0 && m_avg < thr[m_level] - 8) lvl_n = m_level - 1;
    cnt_n = m_cnt;
    if (c) cnt_n = 0;
    else if (e && v) cnt_n = (m_level == 3) ? ((m_cnt < 16) ? m_cnt + 1 : 16) : 0;
    m_alarm = c ? 1'b0 : (m_alarm || cnt_n == 16);
    if (c) m_peak = 0;
    else if (m_avg > m_peak) m_peak = m_avg;
    m_level = lvl_n;
    m_cnt = cnt_n;
    if (e && v) begin
      for (int i = 7; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = int'(s);
      sum = 0;
      for (int i = 0; i < 8; i++) sum += m_win[i];
      m_avg = sum / 8;
      if (m_fill < 8) m_fill++;
      if (m_fill == 8) m_avalid = 1'b1;
    end
  endtask

  function automatic logic [15:0] model_pack(bit p);
    logic [7:0] uo, uio;
    logic [1:0] lv;
    lv = 2'(m_level);
    uo = (p && PEAK_EN) ? 8'(m_peak) : 8'(m_avg);
    uio = {m_alarm, lv, m_avalid, 4'b0000};
    return {uo, uio};
  endfunction

  // driver: apply one cycle, push the expected outputs, compare after the edge
  task automatic step(bit e, bit v, bit c, bit p, logic [7:0] s,
                      bit use_exp, logic [15:0] exp_v, string name);
    logic [15:0] got, want;
    ena = e;
    ui_in = s;
    uio_in = {5'b00000, p, c, v};
    model_edge(e, v, c, s);
    exp_q.push_back(use_exp ? exp_v : model_pack(p));
    @(posedge clk);
    #1;
    got = {uo_out, uio_out};
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: uo/uio got %h expected %h", name, got, want);
    end
  endtask

  task automatic sample(logic [7:0] s, string name);
    step(1'b1, 1'b1, 1'b0, 1'b0, s, 1'b0, 16'h0, name);
  endtask

  task automatic idle(string name);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0, name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ena = 1'($urandom_range(0, 1));
      ui_in = 8'($urandom_range(0, 255));
      uio_in = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check_val("reset_uo", int'(uo_out), 0);
      check_val("reset_uio", int'(uio_out), 0);
      check_val("reset_oe", int'(uio_oe), 8'hF0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // window fill: avg ramps 12..100, level 1 one clock after avg hits 87
    tbl[0]  = '{8'd100, 8'd12,  8'h00};
    tbl[1]  = '{8'd100, 8'd25,  8'h00};
    tbl[2]  = '{8'd100, 8'd37,  8'h00};
    tbl[3]  = '{8'd100, 8'd50,  8'h00};
    tbl[4]  = '{8'd100, 8'd62,  8'h00};
    tbl[5]  = '{8'd100, 8'd75,  8'h00};
    tbl[6]  = '{8'd100, 8'd87,  8'h00};
    tbl[7]  = '{8'd100, 8'd100, 8'h30};
    // climb: level 1 -> 2 -> 3 as avg crosses 128 and 176
    tbl[8]  = '{8'd200, 8'd112, 8'h30};
    tbl[9]  = '{8'd200, 8'd125, 8'h30};
    tbl[10] = '{8'd200, 8'd137, 8'h30};
    tbl[11] = '{8'd200, 8'd150, 8'h50};
    tbl[12] = '{8'd200, 8'd162, 8'h50};
    tbl[13] = '{8'd200, 8'd175, 8'h50};
    tbl[14] = '{8'd200, 8'd187, 8'h50};
    tbl[15] = '{8'd200, 8'd200, 8'h70};

    ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    model_reset();
    do_reset();

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, tbl[i].sample, 1'b1,
           {tbl[i].exp_uo, tbl[i].exp_uio}, $sformatf("tbl[%0d]", i));
    end

    // alarm sets on the 16th accepted level-3 sample and is sticky
    for (int i = 0; i < 15; i++) sample(8'd200, "alarm_run");
    check_val("alarm_before_16", int'(uio_out[7]), 0);
    sample(8'd200, "alarm_run16");
    check_val("alarm_after_16", int'(uio_out[7]), 1);
    idle("alarm_hold");
    idle("alarm_hold");
    check_val("alarm_sticky", int'(uio_out[7]), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0, "alarm_clear");
    check_val("alarm_cleared", int'(uio_out[7]), 0);

    // clear on the very cycle that would set the alarm
    for (int i = 0; i < 15; i++) sample(8'd200, "clr_race_run");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'd200, 1'b0, 16'h0, "clr_race");
    check_val("clear_beats_set", int'(uio_out[7]), 0);
    sample(8'd200, "clr_race_after");
    check_val("clear_beats_set_after", int'(uio_out[7]), 0);

    // ena=0 gating: strobes of 255 ignored, counter holds at 1
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 1'b0, 16'h0, "gated");
    check_val("gated_avg", int'(uo_out), 200);
    check_val("gated_avalid", int'(uio_out[4]), 1);
    for (int i = 0; i < 14; i++) sample(8'd200, "gated_resume");
    check_val("gated_cnt_15", int'(uio_out[7]), 0);
    sample(8'd200, "gated_cnt_16");
    check_val("gated_cnt_alarm", int'(uio_out[7]), 1);

    // hysteresis around the level-2 entry threshold
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0, "hyst_clear");
    for (int i = 0; i < 8; i++) sample(8'd130, "hyst_fill");
    for (int i = 0; i < 4; i++) idle("hyst_settle");
    check_val("hyst_avg130", int'(uo_out), 130);
    check_val("hyst_lvl_at130", int'(uio_out[6:5]), 2);
    sample(8'd82, "hyst_to124");
    check_val("hyst_avg124", int'(uo_out), 124);
    for (int i = 0; i < 3; i++) idle("hyst_hold");
    check_val("hyst_lvl_at124", int'(uio_out[6:5]), 2);
    sample(8'd90, "hyst_to119");
    check_val("hyst_avg119", int'(uo_out), 119);
    check_val("hyst_lvl_same_clk", int'(uio_out[6:5]), 2);
    idle("hyst_drop");
    check_val("hyst_lvl_dropped", int'(uio_out[6:5]), 1);

    // random traffic in alternating low/high sample bands
    for (int i = 0; i < 400; i++) begin
      logic [7:0] s;
      s = ((i / 60) % 2 == 1) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 120));
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)), s,
           1'b0, 16'h0, "random");
    end

    // reset in the middle of operation, then refill
    do_reset();
    for (int i = 0; i < 10; i++) sample(8'($urandom_range(0, 255)), "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
